match_streak_detector: RTL and testbench
========================================

MATCH_STREAK_DETECTOR -- requirements
Module: match_streak_detector

Interface
REQ-001 Parameter LOCK_COUNT, default 4: consecutive equal samples required to assert lock; legal range 1 to 2**CNT_W-1.
REQ-002 Parameter CNT_W, default 4: width of the streak counter.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1: asynchronous, active-low reset.
REQ-005 in_valid  input  1: a/b carry a sample this cycle.
REQ-006 a  input  2: first operand.
REQ-007 b  input  2: second operand.
REQ-008 clear  input  1: synchronous clear of all state.
REQ-009 out_valid  output  1: one-cycle pulse, one cycle after each accepted sample.
REQ-010 match  output  1: registered equality result of the last accepted sample.
REQ-011 lock  output  1: high while the FSM is in LOCKED.
REQ-012 streak  output  CNT_W: current count of consecutive equal samples.
REQ-013 mismatch_cnt  output  8: total unequal samples since reset or clear.

Function
REQ-014 The block SHALL accept a sample on every rising edge with in_valid=1; there is no backpressure.
REQ-015 With in_valid=0, all state and outputs SHALL hold, except out_valid, which SHALL be 0.
REQ-016 All outputs SHALL be registered; results for the sample accepted at edge N SHALL be visible after edge N, giving 1-cycle latency.
REQ-017 The FSM SHALL have three states: IDLE, TRACK, LOCKED.
REQ-018 In IDLE, an equal sample SHALL set streak=1 and go to TRACK; if LOCK_COUNT=1 it SHALL go to LOCKED instead.
REQ-019 In IDLE, an unequal sample SHALL keep streak=0 and stay in IDLE.
REQ-020 In TRACK, an equal sample SHALL increment streak; when the new streak equals LOCK_COUNT, the FSM SHALL enter LOCKED.
REQ-021 In TRACK or LOCKED, an unequal sample SHALL set streak=0 and go to IDLE; lock SHALL fall on that same edge.
REQ-022 In LOCKED, equal samples SHALL increment streak, saturating at 2**CNT_W-1 with no wrap; the FSM SHALL stay in LOCKED.
REQ-023 Every unequal accepted sample SHALL increment mismatch_cnt, saturating at 255 with no wrap.
REQ-024 clear SHALL take priority over a simultaneous in_valid: the sample is discarded, all outputs return to reset values, and the FSM enters IDLE.
REQ-025 match SHALL be 1 if and only if a==b on all 2 bits for the accepted sample.

Reset
REQ-026 reset_n=0 SHALL immediately, without waiting for a clock edge, force: FSM=IDLE, out_valid=0, match=0, lock=0, streak=0, mismatch_cnt=0.
REQ-027 Reset asserted mid-streak or while LOCKED SHALL discard all history; the first sample after release SHALL be treated as coming from IDLE.

Structure
REQ-028 The FSM state enum and the mismatch saturation constant (255) SHALL live in shared package match_pkg.
REQ-029 The equality compare SHALL be done by instantiating the existing eq2 comparator as the single sub-module; no inline compare is allowed.
REQ-030 The implementation SHALL use one registered FSM with separate next-state logic; counters SHALL update in the same clocked process.

Verification (LOCK_COUNT=4, CNT_W=4)
REQ-031 Four valid samples a=b=2'b10 -> streak 1,2,3,4; lock rises after the 4th edge; out_valid pulses four times.
REQ-032 Three equal samples, then a=01,b=11, then one equal sample -> streak 3, then 0 (lock stays 0), then 1; mismatch_cnt=1.
REQ-033 Twenty consecutive equal samples -> streak saturates at 15; lock stays 1; a later a=11,b=01 -> lock=0, streak=0 on the next edge.
REQ-034 300 unequal samples -> mismatch_cnt saturates at 255; lock stays 0 throughout.
REQ-035 clear asserted together with an equal valid sample while LOCKED -> all outputs return to reset values and the sample is not counted.
REQ-036 reset_n pulled low between clock edges while LOCKED -> lock, streak and match go to 0 immediately; normal operation resumes after release.

Source files
------------

// File: rtl/match_pkg.sv
// Shared types and constants for the match streak detector.
// Holds the FSM state encoding and the mismatch counter ceiling.
package match_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] MISMATCH_MAX = 8'd255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == MISMATCH_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/eq2.sv
// Two-bit equality comparator.
// eq_o is high only when every bit of a_i matches b_i.
module eq2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic       eq_o
);

    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/match_streak_detector.sv
// Counts consecutive equal a/b samples, locks after LOCK_COUNT of them,
// and keeps a saturating tally of unequal samples.
module match_streak_detector
    import match_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [1:0]       a,
    input  logic [1:0]       b,
    input  logic             clear,
    output logic             out_valid,
    output logic             match,
    output logic             lock,
    output logic [CNT_W-1:0] streak,
    output logic [7:0]       mismatch_cnt
);

    localparam logic [CNT_W-1:0] STREAK_MAX = '1;
    localparam logic [CNT_W-1:0] STREAK_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOCK_VAL   = CNT_W'(LOCK_COUNT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] streak_q, streak_d;
    logic [7:0]       mm_q, mm_d;
    logic             match_q, match_d;
    logic             valid_q, valid_d;
    logic             lock_q, lock_d;
    logic             eq_w;

    eq2 u_eq (
        .a_i  (a),
        .b_i  (b),
        .eq_o (eq_w)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            streak_q <= '0;
            mm_q     <= '0;
            match_q  <= 1'b0;
            valid_q  <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            mm_q     <= mm_d;
            match_q  <= match_d;
            valid_q  <= valid_d;
            lock_q   <= lock_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        mm_d     = mm_q;
        match_d  = match_q;
        valid_d  = 1'b0;
        lock_d   = lock_q;
        if (clear) begin
            // clear wins over a same-cycle sample, which is dropped
            state_d  = IDLE;
            streak_d = '0;
            mm_d     = '0;
            match_d  = 1'b0;
            lock_d   = 1'b0;
        end else if (in_valid) begin
            valid_d = 1'b1;
            match_d = eq_w;
            if (!eq_w) begin
                state_d  = IDLE;
                streak_d = '0;
                mm_d     = sat_inc8(mm_q);
            end else begin
                unique case (state_q)
                    IDLE: begin
                        streak_d = STREAK_ONE;
                        state_d  = (LOCK_COUNT == 1) ? LOCKED : TRACK;
                    end
                    TRACK: begin
                        streak_d = streak_q + STREAK_ONE;
                        if (streak_d == LOCK_VAL) begin
                            state_d = LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + STREAK_ONE;
                        end
                    end
                    default: begin
                        state_d  = IDLE;
                        streak_d = '0;
                    end
                endcase
            end
            lock_d = (state_d == LOCKED);
        end
    end

    assign out_valid    = valid_q;
    assign match        = match_q;
    assign lock         = lock_q;
    assign streak       = streak_q;
    assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_match_streak_detector.sv
// Scoreboard bench for match_streak_detector with LOCK_COUNT=4, CNT_W=4.
module tb_match_streak_detector;

    localparam int LC = 4;
    localparam int CW = 4;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic          in_valid = 1'b0;
    logic          clear    = 1'b0;
    logic [1:0]    a        = 2'b00;
    logic [1:0]    b        = 2'b00;
    logic          out_valid;
    logic          match;
    logic          lock;
    logic [CW-1:0] streak;
    logic [7:0]    mismatch_cnt;

    typedef struct packed {
        logic          v;
        logic          m;
        logic          l;
        logic [CW-1:0] s;
        logic [7:0]    mm;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state
    logic m_v  = 1'b0;
    logic m_m  = 1'b0;
    int   m_s  = 0;
    int   m_mm = 0;

    match_streak_detector #(
        .LOCK_COUNT (LC),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .a            (a),
        .b            (b),
        .clear        (clear),
        .out_valid    (out_valid),
        .match        (match),
        .lock         (lock),
        .streak       (streak),
        .mismatch_cnt (mismatch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t observe();
        obs_t o;
        o.v  = out_valid;
        o.m  = match;
        o.l  = lock;
        o.s  = streak;
        o.mm = mismatch_cnt;
        return o;
    endfunction

    function automatic obs_t model_exp();
        obs_t o;
        o.v  = m_v;
        o.m  = m_m;
        o.l  = (m_s >= LC);
        o.s  = CW'(m_s);
        o.mm = 8'(m_mm);
        return o;
    endfunction

    task automatic model_zero();
        m_v  = 1'b0;
        m_m  = 1'b0;
        m_s  = 0;
        m_mm = 0;
    endtask

    // drive one cycle, push the expected result, return just after the edge
    task automatic drive(input logic v, input logic [1:0] av,
                         input logic [1:0] bv, input logic clr);
        @(negedge clk);
        in_valid = v;
        a        = av;
        b        = bv;
        clear    = clr;
        if (clr) begin
            model_zero();
        end else if (v) begin
            m_v = 1'b1;
            m_m = (av == bv);
            if (av == bv) begin
                if (m_s < (1 << CW) - 1) m_s++;
            end else begin
                m_s = 0;
                if (m_mm < 255) m_mm++;
            end
        end else begin
            m_v = 1'b0;
        end
        exp_q.push_back(model_exp());
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        got = observe();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_state got=%p exp=0", got);
        end
        reset_n = 1'b1;
        model_zero();
        exp_q.delete();
    endtask

    task automatic test_lock();
        obs_t got, ex;
        drive(1'b0, 2'b00, 2'b00, 1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b10, 2'b10, 1'b0);
            got = observe();
            ex  = exp_q.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL lock_step%0d got=%p exp=%p", i, got, ex);
            end
        end
        checks++;
        if (lock !== 1'b1 || streak !== 4'd4) begin
            errors++;
            $display("FAIL lock_after_4 got=%b/%0d exp=1/4", lock, streak);
        end
    endtask

    task automatic test_idle_hold();
        obs_t got, ex;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b01, 2'b10, 1'b0);
            got = observe();
            ex  = exp_q.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL idle_hold%0d got=%p exp=%p", i, got, ex);
            end
        end
    endtask

    task automatic test_break();
        obs_t got, ex;
        logic [1:0] av[5] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b01};
        logic [1:0] bv[5] = '{2'b00, 2'b11, 2'b10, 2'b11, 2'b01};
        drive(1'b0, 2'b00, 2'b00, 1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, av[i], bv[i], 1'b0);
            got = observe();
            ex  = exp_q.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL break_step%0d got=%p exp=%p", i, got, ex);
            end
        end
        checks++;
        if (mismatch_cnt !== 8'd1 || streak !== 4'd1 || lock !== 1'b0) begin
            errors++;
            $display("FAIL break_final got=mm%0d s%0d l%b exp=mm1 s1 l0",
                     mismatch_cnt, streak, lock);
        end
    endtask

    task automatic test_saturate();
        obs_t got, ex;
        logic [1:0] v;
        drive(1'b0, 2'b00, 2'b00, 1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 20; i++) begin
            v = 2'(i);
            drive(1'b1, v, v, 1'b0);
            got = observe();
            ex  = exp_q.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL sat_step%0d got=%p exp=%p", i, got, ex);
            end
        end
        checks++;
        if (streak !== 4'd15 || lock !== 1'b1) begin
            errors++;
            $display("FAIL sat_peak got=%0d/%b exp=15/1", streak, lock);
        end
        drive(1'b1, 2'b11, 2'b01, 1'b0);
        got = observe();
        ex  = exp_q.pop_front();
        checks++;
        if (got !== ex) begin
            errors++;
            $display("FAIL sat_break got=%p exp=%p", got, ex);
        end
    endtask

    task automatic test_mismatch_sat();
        obs_t got, ex;
        logic [1:0] av, bv;
        drive(1'b0, 2'b00, 2'b00, 1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 300; i++) begin
            av = 2'($urandom_range(0, 3));
            bv = av ^ 2'($urandom_range(1, 3));
            drive(1'b1, av, bv, 1'b0);
            got = observe();
            ex  = exp_q.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL mm_step%0d got=%p exp=%p", i, got, ex);
            end
        end
        checks++;
        if (mismatch_cnt !== 8'd255) begin
            errors++;
            $display("FAIL mm_sat got=%0d exp=255", mismatch_cnt);
        end
    endtask

    task automatic test_clear();
        obs_t got, ex;
        drive(1'b0, 2'b00, 2'b00, 1'b1);
        void'(exp_q.pop_front());
        drive(1'b1, 2'b01, 2'b10, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b11, 2'b11, 1'b0);
            void'(exp_q.pop_front());
        end
        drive(1'b1, 2'b10, 2'b10, 1'b1);
        got = observe();
        ex  = exp_q.pop_front();
        checks++;
        if (got !== ex) begin
            errors++;
            $display("FAIL clear_locked got=%p exp=%p", got, ex);
        end
        drive(1'b1, 2'b00, 2'b00, 1'b0);
        got = observe();
        ex  = exp_q.pop_front();
        checks++;
        if (got !== ex) begin
            errors++;
            $display("FAIL clear_resume got=%p exp=%p", got, ex);
        end
    endtask

    task automatic test_async_reset();
        obs_t got, ex;
        drive(1'b0, 2'b00, 2'b00, 1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b01, 2'b01, 1'b0);
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        in_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        got = observe();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL async_reset got=%p exp=0", got);
        end
        model_zero();
        exp_q.delete();
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b10, 2'b10, 1'b0);
            got = observe();
            ex  = exp_q.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL post_reset%0d got=%p exp=%p", i, got, ex);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, ex;
        logic       v;
        logic [1:0] av, bv;
        drive(1'b0, 2'b00, 2'b00, 1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 80; i++) begin
            v  = ($urandom_range(0, 4) != 0);
            av = 2'($urandom_range(0, 3));
            bv = ($urandom_range(0, 3) != 0) ? av : 2'($urandom_range(0, 3));
            drive(v, av, bv, 1'b0);
            got = observe();
            ex  = exp_q.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL rand_step%0d got=%p exp=%p", i, got, ex);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_idle_hold();
        test_break();
        test_saturate();
        test_mismatch_sat();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
